// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, op-codes and FSM state type for the calculator key sequencer
package calc_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ABS = 3'b010;

    localparam int KEY_ADD = 0;
    localparam int KEY_SUB = 1;
    localparam int KEY_ABS = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    // Fixed-priority pick among same-cycle press pulses: ADD > SUB > ABS.
    function automatic logic [2:0] press_to_op(input logic [2:0] press);
        if (press[KEY_ADD])      return OP_ADD;
        else if (press[KEY_SUB]) return OP_SUB;
        else                     return OP_ABS;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one pushbutton: 2-flop synchronizer, debounce counter, press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_raw_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // Synchronize the raw key; keys idle high, so reset to released.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the debounced level; flip after a full run.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    press_q <= ~sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - debounced key front-end that latches operands and holds calculator results
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIDTH           = WIDTH_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [2:0]         KEY,
    input  logic [2*WIDTH-1:0] SW,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic [2:0]         op,
    input  logic [WIDTH-1:0]   calc_r,
    input  logic               calc_ovf,
    output logic [WIDTH-1:0]   r_hold,
    output logic               ovf_hold,
    output logic               result_valid,
    output logic               busy
);

    logic [2:0] press;

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk_i    (CLOCK_50),
                .rst_i    (reset),
                .key_raw_i(KEY[k]),
                .press_o  (press[k])
            );
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] r_hold_q;
    logic             ovf_hold_q;
    logic             result_valid_q;
    logic             busy_q;

    logic             ev_valid;
    logic [2:0]       ev_op;

    // Reduce same-cycle presses to one request; losers are simply discarded.
    always_comb begin
        ev_valid = |press;
        ev_op    = press_to_op(press);
    end

    // Request sequencer: latch operands, wait one settle cycle, capture the result.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= OP_ADD;
            r_hold_q       <= '0;
            ovf_hold_q     <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_SHOW: begin
                    if (ev_valid) begin
                        state_q        <= ST_LATCH;
                        a_q            <= SW[2*WIDTH-1:WIDTH];
                        b_q            <= SW[WIDTH-1:0];
                        op_q           <= ev_op;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state_q        <= ST_SHOW;
                    r_hold_q       <= calc_r;
                    ovf_hold_q     <= calc_ovf;
                    result_valid_q <= 1'b1;
                    busy_q         <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign op           = op_q;
    assign r_hold       = r_hold_q;
    assign ovf_hold     = ovf_hold_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - directed self-checking bench for calc_key_sequencer
module tb_calc_key_sequencer;

    localparam int D = 4;
    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [2:0]   KEY;
    logic [7:0]   SW;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic [2:0]   op;
    logic [W-1:0] calc_r;
    logic         calc_ovf;
    logic [W-1:0] r_hold;
    logic         ovf_hold;
    logic         result_valid;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int busy_rises;
    int rv_low;
    int stray;
    logic busy_prev;
    bit ok;

    calc_key_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .WIDTH          (W)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .KEY         (KEY),
        .SW          (SW),
        .a_out       (a_out),
        .b_out       (b_out),
        .op          (op),
        .calc_r      (calc_r),
        .calc_ovf    (calc_ovf),
        .r_hold      (r_hold),
        .ovf_hold    (ovf_hold),
        .result_valid(result_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational 4-bit calculator model driven by the latched operands.
    logic [4:0] sa, sb, s;
    always_comb begin
        sa = {a_out[W-1], a_out};
        sb = {b_out[W-1], b_out};
        case (op)
            3'b000:  s = sa + sb;
            3'b001:  s = sa - sb;
            default: s = a_out[W-1] ? (5'd0 - sa) : sa;
        endcase
        calc_r   = s[3:0];
        calc_ovf = s[4] ^ s[3];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_mon();
        tick();
        if (busy && !busy_prev) busy_rises++;
        if (!result_valid) rv_low++;
        busy_prev = busy;
    endtask

    task automatic wait_busy(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_a"},   32'(a_out),        32'h0);
        check_eq({tag, "_b"},   32'(b_out),        32'h0);
        check_eq({tag, "_op"},  32'(op),           32'h0);
        check_eq({tag, "_r"},   32'(r_hold),       32'h0);
        check_eq({tag, "_ovf"}, 32'(ovf_hold),     32'h0);
        check_eq({tag, "_rv"},  32'(result_valid), 32'h0);
        check_eq({tag, "_bsy"}, 32'(busy),         32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        KEY   = 3'b111;
        SW    = 8'h00;
        repeat (3) tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        // ADD 0+1 with exact latency from raw key fall
        SW  = 8'h01;
        KEY = 3'b110;
        repeat (D + 2) tick();
        check_eq("lat_busy_early", 32'(busy), 32'h0);
        tick();
        check_eq("lat_busy", 32'(busy), 32'h1);
        check_eq("add_a", 32'(a_out), 32'h0);
        check_eq("add_b", 32'(b_out), 32'h1);
        check_eq("add_op", 32'(op), 32'h0);
        check_eq("add_rv_latch", 32'(result_valid), 32'h0);
        tick();
        check_eq("add_rv_capture", 32'(result_valid), 32'h0);
        check_eq("add_busy_capture", 32'(busy), 32'h1);
        tick();
        check_eq("add_rv", 32'(result_valid), 32'h1);
        check_eq("add_r", 32'(r_hold), 32'h1);
        check_eq("add_ovf", 32'(ovf_hold), 32'h0);
        check_eq("add_busy_show", 32'(busy), 32'h0);
        repeat (3) tick();
        KEY = 3'b111;
        repeat (D + 4) tick();
        SW = 8'hFF;
        repeat (3) tick();
        check_eq("sw_hold_a", 32'(a_out), 32'h0);
        check_eq("sw_hold_b", 32'(b_out), 32'h1);

        // bouncing SUB key: one event only
        SW = 8'h23;
        busy_rises = 0;
        rv_low = 0;
        busy_prev = busy;
        for (int i = 0; i < 6; i++) begin
            KEY[1] = ~KEY[1];
            repeat (2) tick_mon();
        end
        KEY[1] = 1'b0;
        repeat (20) tick_mon();
        check_eq("bounce_events", 32'(busy_rises), 32'd1);
        check_eq("bounce_rv_low", 32'(rv_low), 32'd2);
        check_eq("sub_op", 32'(op), 32'h1);
        check_eq("sub_a", 32'(a_out), 32'h2);
        check_eq("sub_b", 32'(b_out), 32'h3);
        check_eq("sub_r", 32'(r_hold), 32'hF);
        check_eq("sub_ovf", 32'(ovf_hold), 32'h0);
        KEY = 3'b111;
        repeat (D + 4) tick();

        // ADD overflow 7+1
        SW  = 8'h71;
        KEY = 3'b110;
        wait_busy(ok);
        check_eq("ovf_event", 32'(ok), 32'h1);
        repeat (2) tick();
        check_eq("ovf_r", 32'(r_hold), 32'h8);
        check_eq("ovf_flag", 32'(ovf_hold), 32'h1);
        check_eq("ovf_rv", 32'(result_valid), 32'h1);
        KEY = 3'b111;
        repeat (D + 4) tick();

        // simultaneous ADD+ABS, then SUB while busy
        SW = 8'h12;
        busy_rises = 0;
        busy_prev = busy;
        KEY = 3'b010;
        tick_mon();
        KEY = 3'b000;
        repeat (20) tick_mon();
        check_eq("prio_events", 32'(busy_rises), 32'd1);
        check_eq("prio_op", 32'(op), 32'h0);
        check_eq("prio_r", 32'(r_hold), 32'h3);
        check_eq("prio_rv", 32'(result_valid), 32'h1);
        check_eq("prio_state", 32'(dut.state_q), 32'd3);
        KEY = 3'b111;
        repeat (D + 4) tick();

        // reset while in CAPTURE
        SW  = 8'h44;
        KEY = 3'b110;
        wait_busy(ok);
        check_eq("mid_event", 32'(ok), 32'h1);
        tick();
        check_eq("mid_capture_state", 32'(dut.state_q), 32'd2);
        reset = 1'b1;
        KEY   = 3'b111;
        tick();
        check_all_zero("mid_rst");
        check_eq("mid_rst_state", 32'(dut.state_q), 32'd0);
        reset = 1'b0;
        stray = 0;
        repeat (20) begin
            tick();
            if (result_valid || busy) stray++;
        end
        check_eq("post_rst_quiet", 32'(stray), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
